// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator
// Bit-serial magnitude comparator. It walks the captured operands MSB
// first, one bit per clock, and stops at the first differing bit or after
// the LSB. The result is held in three one-hot flags until the next
// accepted start.
// Optional feature: define SERIAL_COMP_SIGNED_EN to add two's complement
// comparison, selected per request by signed_mode.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             aGTb,
  output logic             aEQb,
  output logic             aLTb
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             bit_a;
  logic             bit_b;
  logic             a_wins;

`ifdef SERIAL_COMP_SIGNED_EN
  logic             signed_q, signed_d;
`else
  // signed_mode has no function in this build; it is deliberately left unsampled
  logic             unused_signed_mode;
  assign unused_signed_mode = signed_mode;
`endif

  // Bit selection and decision of which operand is larger at the current index
  always_comb begin
    bit_a  = a_q[idx_q];
    bit_b  = b_q[idx_q];
    a_wins = bit_a;
`ifdef SERIAL_COMP_SIGNED_EN
    // In two's complement a set sign bit means the smaller value
    if (signed_q && (idx_q == IDX_MSB)) begin
      a_wins = bit_b;
    end
`endif
  end

  // Next-state logic: capture on start, step one bit per RUN cycle, pulse DONE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
`ifdef SERIAL_COMP_SIGNED_EN
    signed_d = signed_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
`ifdef SERIAL_COMP_SIGNED_EN
          signed_d = signed_mode;
`endif
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          idx_d   = IDX_MSB;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bit_a != bit_b) begin
          gt_d    = a_wins;
          lt_d    = ~a_wins;
          state_d = DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= IDX_MSB;
      a_q     <= '0;
      b_q     <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
`ifdef SERIAL_COMP_SIGNED_EN
      signed_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
`ifdef SERIAL_COMP_SIGNED_EN
      signed_q <= signed_d;
`endif
    end
  end

  // Status and result outputs come straight from registered state
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    aGTb = gt_q;
    aEQb = eq_q;
    aLTb = lt_q;
  end

endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, the request to compare a and b.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each, the operands, sampled only on an accepted start.
REQ-006 The block SHALL have port signed_mode, input, 1 bit, sampled with a and b (used only per REQ-025).
REQ-007 The block SHALL have port busy, output, 1 bit, high while a comparison is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse when the result becomes valid.
REQ-009 The block SHALL have ports aGTb, aEQb and aLTb, output, 1 bit each, the registered result flags.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 In IDLE, start=1 SHALL be accepted: capture a, b and signed_mode, clear all result flags, set bit index to WIDTH-1, and go to RUN.
REQ-012 start SHALL be ignored in RUN and DONE, with no effect on captured operands or on the comparison in progress.
REQ-013 In RUN, one bit per cycle SHALL be compared, MSB first, at the current index.
REQ-014 If the captured bits differ in RUN: set aGTb (a bit=1) or aLTb (b bit=1), then go to DONE.
REQ-015 If the bits are equal and index=0: set aEQb and go to DONE.
REQ-016 If the bits are equal and index>0: decrement the index and remain in RUN.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 busy SHALL be 1 in RUN, and 0 in IDLE and DONE.
REQ-019 Latency: done SHALL be high in cycle k+1 after the start-sampling edge, where k = number of bits examined (1..WIDTH).
REQ-020 Exactly one result flag SHALL be high from DONE entry until the next accepted start; all flags SHALL be 0 before the first result.
REQ-021 A start asserted in the same cycle done=1 SHALL be ignored; a start on the following cycle (IDLE) SHALL be accepted.

Reset
REQ-022 With rst=1 at a clock edge, the block SHALL enter IDLE with busy, done, aGTb, aEQb and aLTb all 0, and the index set to WIDTH-1.
REQ-023 rst SHALL take priority over start and over any state; a reset during RUN SHALL abort the comparison with no done pulse.
REQ-024 The first start SHALL be accepted on the first edge with rst=0.

Configuration
REQ-025 With macro SERIAL_COMP_SIGNED_EN defined and captured signed_mode=1, a MSB mismatch SHALL be inverted: a MSB=1 gives aLTb and b MSB=1 gives aGTb (two's complement); lower bits SHALL compare unsigned.
REQ-026 Without SERIAL_COMP_SIGNED_EN, signed_mode SHALL be ignored (no capture logic) and all comparisons SHALL be unsigned.

Verification (WIDTH=8)
REQ-027 Bench: a=0x80, b=0x7F, start pulse -> aGTb=1, k=1, done 2 cycles after start, busy high for 1 cycle.
REQ-028 Bench: a=0x03, b=0x05 -> aLTb=1, k=6, done at cycle 7; flags stay held until the next start.
REQ-029 Bench: a=b=0x5A -> aEQb=1, k=8, done at cycle 9; a start held high throughout RUN -> no restart and operands unchanged.
REQ-030 Bench: SERIAL_COMP_SIGNED_EN defined, signed_mode=1, a=0x80, b=0x01 -> aLTb=1, k=1; same stimulus with the macro undefined -> aGTb=1.
REQ-031 Bench: rst=1 on the 3rd RUN cycle of a=b=0xFF -> next cycle state IDLE, all outputs 0, no done pulse; a new start then completes normally.
REQ-032 Bench: start asserted in the done cycle -> ignored; start on the next cycle -> accepted, done after k+1 cycles.
